jpeg_mcu_raster: RTL
====================

# jpeg_mcu_raster

Converts the decoder's MCU-ordered pixel stream into raster order. Each MCU strip (8 lines for 4:4:4 / gray, 16 lines for 4:1:1) is buffered in an internal strip RAM, then drained line by line on a valid/ready pixel port. Sits directly downstream of `jpeg_top`: it consumes `bo_we/bo_begin/bo_end/bo_data/bo_type` and drives its `bi_next`.

## Interface
- `MAX_W`, default 1024: maximum image width in pixels; must be a power of two and a multiple of 16. The strip RAM holds 16 × `MAX_W` words of 24 bits.
- `clk  input  1  clock; all logic is on the rising edge`
- `rst  input  1  asynchronous, active-low reset`
- `mcu_w  input  13  MCUs per row; sampled on an accepted `ai_begin``
- `ai_we  input  1  pixel strobe from the decoder`
- `ai_begin  input  1  first pixel of the frame; qualified by `ai_we``
- `ai_end  input  1  last pixel of the frame; qualified by `ai_we``
- `ai_data  input  32  {R,G,B,8'h00}`
- `ai_type  input  1  1 = 4:1:1 (16×16 MCU), 0 = 8×8 MCU; sampled on `ai_begin``
- `ao_next  output  1  ready to accept pixels; drives the decoder's `bi_next``
- `po_valid  output  1  raster pixel valid`
- `po_ready  input  1  sink accepts the pixel`
- `po_data  output  24  {R,G,B}`
- `po_sof  output  1  first pixel of the frame`
- `po_eol  output  1  last pixel of the line`
- `po_eof  output  1  last pixel of the frame`
- `err  output  1  sticky protocol error; present only with `JPEG_RASTER_ERR_EN``

## Operation
- **Reset values:** `ao_next`=1, `po_valid`=0, `po_sof`/`po_eol`/`po_eof`=0, `po_data`=0, `err`=0. State=FILL, all counters 0.
- **Derived constants:** S = 16 if the latched type is 1, else 8. N = S×S.
- **Write address:** {row, col} with row = `pix_cnt` / S and col = `mcu_x`×S + `pix_cnt` mod S. Column width is log2(`MAX_W`); overflow wraps modulo `MAX_W`.
- **FILL state:**
  - `ao_next`=1.
  - Each `ai_we` writes `ai_data[31:8]` to the RAM at the write address.
  - `pix_cnt` (8 bits) increments and wraps at N−1.
  - On wrap, `mcu_x` increments. When `mcu_x` = mcu_w_l−1 and `pix_cnt` = N−1, go to DRAIN.
  - If that pixel carries `ai_end`, set `last_strip`.
- **Accepted `ai_begin`:**
  - Forces `pix_cnt`=0 and `mcu_x`=0, even mid-frame. The strip restarts and partially written data is overwritten.
  - Latches `ai_type` and `mcu_w`; `mcu_w`=0 is latched as 1.
  - Sets the `first_strip` flag.
- **DRAIN state:**
  - `ao_next`=0.
  - A read counter walks row 0..S−1, col 0..mcu_w_l×S−1 in raster order.
  - One registered output stage with one-cycle RAM latency. The read advances when the output stage is empty or `po_ready`=1.
  - `po_sof` = `first_strip` & row 0 & col 0.
  - `po_eol` = last column.
  - `po_eof` = `last_strip` & last row & last column.
  - When the final pixel is accepted: return to FILL, clear `first_strip`, and clear `last_strip`.
- **`ai_we` while `ao_next`=0:** the pixel is ignored and the RAM is not written.
- **Held `po_data`:** stable while `po_valid`=1 and `po_ready`=0.

## Timing
- **Fill:** one pixel per cycle, no bubbles. `ao_next` falls in the cycle after the strip's last pixel is written.
- **Drain start:** first `po_valid` rises 2 cycles after entry to DRAIN (1 cycle address, 1 cycle RAM).
- **Drain rate:** with `po_ready` held high, one pixel per cycle. Drain takes S×mcu_w_l×S + 2 cycles.
- **Back-pressure:** when `po_ready` drops, the read pipe stalls with no loss or duplication.
- **Return to FILL:** `ao_next` rises in the cycle after acceptance of the strip's last pixel.
- **Same-edge events:** `ai_begin` and `ai_end` on the same pixel (1-MCU image) form a single-strip frame with `po_sof` and `po_eof` both asserted on their respective pixels.
- **Asynchronous reset mid-drain:** outputs return to reset values immediately. RAM contents are undefined afterwards.

## Configuration
- **`JPEG_RASTER_ERR_EN` defined:** `err` sets and holds until reset on any of:
  - `ai_we` while `ao_next`=0;
  - `ai_begin` when `pix_cnt`≠0 or `mcu_x`≠0;
  - mcu_w_l×S > `MAX_W`;
  - `ai_end` on a pixel that is not the last of a strip.
- **`JPEG_RASTER_ERR_EN` undefined:** the check logic is removed and `err` is tied to 0. Datapath behaviour is identical.

## Test plan
- **8×8 frame:** mcu_w=2, type 0, 128 pixels with data = index, `po_ready`=1.
  - Expect 8 lines of 16 pixels.
  - Line 0 = idx 0..7, 64..71.
  - `po_sof` on the first pixel, `po_eol` every 16th pixel, `po_eof` on the 128th.
- **4:1:1 frame:** mcu_w=1, type 1, two strips (512 pixels).
  - Expect 32 lines of 16 pixels; pixel (x,y) = (y mod 16)×16 + x + 256×(y/16).
  - `ao_next` low during each drain.
- **Back-pressure:** `po_ready` toggles 1-0-1 with random stalls. The output sequence must be identical to the `po_ready`=1 run, and `po_data` must be held during stalls.
- **Stray write:** `ai_we` pulse with data 0xFFFFFF00 during DRAIN.
  - No output pixel equals 0xFFFFFF.
  - `err`=1 with `JPEG_RASTER_ERR_EN`, 0 without it.
- **Resync:** `ai_begin` after 10 pixels of a strip restarts the frame. Output matches a clean frame, and `err`=1 (ERR_EN).
- **Reset mid-drain:** assert `rst` low after 5 output pixels. `po_valid`=0 and `ao_next`=1 immediately; the next frame is output correctly.

Source files
------------

// File: rtl/jpeg_mcu_raster.sv
// jpeg_mcu_raster
// Reorders the decoder's MCU-ordered pixel stream into raster order. One MCU
// strip (8 lines for 8x8 MCUs, 16 lines for 4:1:1) is written into a strip RAM
// and then drained line by line on a valid/ready pixel port.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   mcu_w[12:0]       MCUs per row, latched on an accepted ai_begin (0 -> 1)
//   ai_we             decoder pixel strobe; only accepted while ao_next=1
//   ai_begin, ai_end  first / last pixel of the frame (qualified by ai_we)
//   ai_data[31:0]     {R,G,B,8'h00}
//   ai_type           1 = 16x16 MCU (4:1:1), 0 = 8x8 MCU; latched on ai_begin
//   ao_next           ready for decoder pixels (high in FILL)
//   po_valid/po_ready raster pixel handshake
//   po_data[23:0]     {R,G,B}
//   po_sof/eol/eof    start of frame / end of line / end of frame markers
//   err               sticky protocol error (only when JPEG_RASTER_ERR_EN is
//                     defined, otherwise tied to 0)
//   dbg_state         current FSM state (0 = FILL, 1 = DRAIN)
//
// Handshake: a raster pixel transfers on a rising edge where po_valid and
// po_ready are both 1; while po_valid=1 and po_ready=0 every po_* output holds.
//
// Optional feature macro: JPEG_RASTER_ERR_EN.
module jpeg_mcu_raster #(
  parameter int MAX_W = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] mcu_w,
  input  logic        ai_we,
  input  logic        ai_begin,
  input  logic        ai_end,
  input  logic [31:0] ai_data,
  input  logic        ai_type,
  output logic        ao_next,
  output logic        po_valid,
  input  logic        po_ready,
  output logic [23:0] po_data,
  output logic        po_sof,
  output logic        po_eol,
  output logic        po_eof,
  output logic        err,
  output logic        dbg_state
);

  localparam int CW = $clog2(MAX_W);
  localparam int AW = CW + 4;

  typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [23:0] mem [0:(16*MAX_W)-1];

  logic [7:0]  pix_cnt;
  logic [12:0] mcu_x, mcu_w_l;
  logic        type_l, first_strip, last_strip;

  logic        rd_busy;
  logic [3:0]  rd_row;
  logic [16:0] rd_col;
  logic        s1_valid, s1_sof, s1_eol, s1_eof, s1_last;
  logic [AW-1:0] s1_addr;
  logic        po_last;
  logic [23:0] rd_q;

  // ---------------- write side ----------------
  logic        wr_acc, beg, eff_type, pix_last, strip_last, fill_done;
  logic [12:0] eff_w, eff_mx;
  logic [7:0]  eff_pix;
  logic [3:0]  wr_row;
  logic [16:0] wr_col_full;
  logic [AW-1:0] wr_addr;

  // A begin pixel is itself pixel 0 of the new frame, so its address is
  // computed from the incoming type/width and zeroed counters.
  assign wr_acc   = ai_we && (state == ST_FILL);
  assign beg      = wr_acc && ai_begin;
  assign eff_type = beg ? ai_type : type_l;
  assign eff_w    = beg ? ((mcu_w == 13'd0) ? 13'd1 : mcu_w) : mcu_w_l;
  assign eff_pix  = beg ? 8'd0 : pix_cnt;
  assign eff_mx   = beg ? 13'd0 : mcu_x;

  assign pix_last   = eff_type ? (eff_pix == 8'd255) : (eff_pix == 8'd63);
  assign strip_last = pix_last && (eff_mx == eff_w - 13'd1);
  assign fill_done  = wr_acc && strip_last;

  assign wr_row      = eff_type ? eff_pix[7:4] : {1'b0, eff_pix[5:3]};
  assign wr_col_full = eff_type ? ({eff_mx, 4'b0000} + {13'd0, eff_pix[3:0]})
                                : ({1'b0, eff_mx, 3'b000} + {14'd0, eff_pix[2:0]});
  // Column wraps modulo MAX_W.
  assign wr_addr = {wr_row, wr_col_full[CW-1:0]};

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= ai_data[31:8];
  end

  // ---------------- FSM ----------------
  logic adv, issue, drain_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (fill_done)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    ao_next   = 1'b0;
    dbg_state = state;
    if (state == ST_FILL) ao_next = 1'b1;
  end

  // ---------------- fill counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt     <= 8'd0;
      mcu_x       <= 13'd0;
      mcu_w_l     <= 13'd1;
      type_l      <= 1'b0;
      first_strip <= 1'b0;
      last_strip  <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (beg) begin
          type_l      <= ai_type;
          mcu_w_l     <= eff_w;
          first_strip <= 1'b1;
          last_strip  <= ai_end;
        end else if (ai_end) begin
          last_strip  <= 1'b1;
        end
        if (pix_last) begin
          pix_cnt <= 8'd0;
          mcu_x   <= strip_last ? 13'd0 : eff_mx + 13'd1;
        end else begin
          pix_cnt <= eff_pix + 8'd1;
          mcu_x   <= eff_mx;
        end
      end
      if (drain_done) begin
        first_strip <= 1'b0;
        last_strip  <= 1'b0;
      end
    end
  end

  // ---------------- drain side ----------------
  logic [3:0]  last_row;
  logic [16:0] line_len, last_col;
  logic        rd_eol, rd_lrow;

  assign last_row = type_l ? 4'd15 : 4'd7;
  assign line_len = type_l ? {mcu_w_l, 4'b0000} : {1'b0, mcu_w_l, 3'b000};
  assign last_col = line_len - 17'd1;
  assign rd_eol   = (rd_col == last_col);
  assign rd_lrow  = (rd_row == last_row);

  // The whole pipe (address stage + RAM/output stage) moves together, so a
  // stall freezes it without dropping or repeating a pixel.
  assign adv        = !po_valid || po_ready;
  assign issue      = (state == ST_DRAIN) && rd_busy && adv;
  assign drain_done = po_valid && po_ready && po_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_busy  <= 1'b0;
      rd_row   <= 4'd0;
      rd_col   <= 17'd0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_last  <= 1'b0;
      po_valid <= 1'b0;
      po_sof   <= 1'b0;
      po_eol   <= 1'b0;
      po_eof   <= 1'b0;
      po_last  <= 1'b0;
    end else begin
      if (fill_done) begin
        rd_busy <= 1'b1;
        rd_row  <= 4'd0;
        rd_col  <= 17'd0;
      end
      if (adv) begin
        s1_valid <= issue;
        po_valid <= s1_valid;
        po_sof   <= s1_valid && s1_sof;
        po_eol   <= s1_valid && s1_eol;
        po_eof   <= s1_valid && s1_eof;
        po_last  <= s1_valid && s1_last;
      end
      if (issue) begin
        s1_addr <= {rd_row, rd_col[CW-1:0]};
        s1_sof  <= first_strip && (rd_row == 4'd0) && (rd_col == 17'd0);
        s1_eol  <= rd_eol;
        s1_last <= rd_eol && rd_lrow;
        s1_eof  <= last_strip && rd_eol && rd_lrow;
        if (rd_eol) begin
          rd_col <= 17'd0;
          if (rd_lrow) rd_busy <= 1'b0;
          else         rd_row  <= rd_row + 4'd1;
        end else begin
          rd_col <= rd_col + 17'd1;
        end
      end
    end
  end

  // RAM output register; masked so po_data reads 0 whenever nothing is valid.
  always_ff @(posedge clk) begin
    if (adv) rd_q <= mem[s1_addr];
  end
  assign po_data = po_valid ? rd_q : 24'd0;

  // ---------------- protocol error ----------------
`ifdef JPEG_RASTER_ERR_EN
  localparam logic [17:0] MAX_W_L = 18'(MAX_W);
  logic err_q, err_set;
  assign err_set = (ai_we && !ao_next)
                || (beg && ((pix_cnt != 8'd0) || (mcu_x != 13'd0)))
                || ({1'b0, line_len} > MAX_W_L)
                || (wr_acc && ai_end && !strip_last);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{ai_data[7:0], wr_col_full[16:CW]};

endmodule
